pipelined_alu: RTL and testbench

PIPELINED_ALU -- requirements
Module: pipelined_alu

---
 rtl/alu_pkg.sv | 32 +++
 rtl/seq_mult.sv | 74 +++++++
 rtl/pipelined_alu.sv | 161 ++++++++++++++++
 tb/tb_pipelined_alu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU:
// opcodes, FSM state type and flag layout.
package alu_pkg;

  localparam logic [3:0] OP_FWD = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_ROL = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic err;
  } flags_t;

endpackage

// File: rtl/seq_mult.sv
// Iterative signed shift-add multiplier,
// one partial product per cycle.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam int W2  = 2 * WIDTH;

  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    pp;
  logic [WIDTH-1:0] mplier;
  logic [SHW-1:0]   cnt;
  logic             busy;
  logic             done_q;
  logic             last;
  logic [WIDTH:0]   hi;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign last  = cnt == SHW'(WIDTH - 1);

  // The sign bit of the multiplier carries negative weight.
  always_comb begin
    pp = '0;
    if (mplier[0])
      pp = last ? -mcand : mcand;
  end

  // Bit 0 is consumed at the start edge so the
  // product is final after WIDTH-1 further edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? a_ext : '0;
      mcand  <= a_ext << 1;
      mplier <= b >> 1;
      cnt    <= SHW'(1);
      busy   <= 1'b1;
      done_q <= 1'b0;
    end else if (busy) begin
      acc    <= acc + pp;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
      if (last) begin
        busy   <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done    = done_q;
  assign product = acc[WIDTH-1:0];
  assign hi      = acc[W2-1:WIDTH-1];
  assign ovf     = ~(&hi | ~|hi);

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU: single-cycle ops plus an
// iterative signed multiply, one output register.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic             mul_ovf;
  logic [WIDTH-1:0] mul_prod;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] rot_r;
  logic [2*WIDTH-1:0] rot_l;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic               alu_err;
  flags_t             alu_flags;
  flags_t             mul_flags;

  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign accept    = in_valid & in_ready;
  assign is_mul    = opcode == OP_MUL;

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (accept & is_mul),
    .a       (data1),
    .b       (data2),
    .done    (mul_done),
    .product (mul_prod),
    .ovf     (mul_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (accept)
          state_d = is_mul ? MUL_RUN : DONE;
      MUL_RUN:
        if (mul_done)
          state_d = DONE;
      DONE:
        if (out_ready)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  assign sh    = data2[SHW-1:0];
  assign sum   = {1'b0, data1} + {1'b0, data2};
  assign diff  = {1'b0, data1} - {1'b0, data2};
  assign rot_r = {data1, data1} >> sh;
  assign rot_l = {data1, data1} << sh;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    unique case (1'b1)
      (opcode == OP_FWD): alu_res = data2;
      (opcode == OP_ADD): begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (data1[WIDTH-1] == data2[WIDTH-1])
                 && (sum[WIDTH-1] != data1[WIDTH-1]);
      end
      (opcode == OP_SUB): begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = ~diff[WIDTH];
        alu_ovf   = (data1[WIDTH-1] != data2[WIDTH-1])
                 && (diff[WIDTH-1] != data1[WIDTH-1]);
      end
      (opcode == OP_AND): alu_res = data1 & data2;
      (opcode == OP_OR):  alu_res = data1 | data2;
      (opcode == OP_XOR): alu_res = data1 ^ data2;
      (opcode == OP_SLL): alu_res = data1 << sh;
      (opcode == OP_SRL): alu_res = data1 >> sh;
      (opcode == OP_SRA): alu_res = $signed(data1) >>> sh;
      (opcode == OP_ROR): alu_res = rot_r[WIDTH-1:0];
      (opcode == OP_ROL): alu_res = rot_l[2*WIDTH-1:WIDTH];
      (opcode == OP_MUL): alu_res = '0;
      default:            alu_err = 1'b1;
    endcase
  end

  // Illegal opcodes report only ERR, so ZERO is masked.
  assign alu_flags.zero  = (alu_res == '0) & ~alu_err;
  assign alu_flags.neg   = alu_res[WIDTH-1];
  assign alu_flags.carry = alu_carry;
  assign alu_flags.ovf   = alu_ovf;
  assign alu_flags.err   = alu_err;

  assign mul_flags.zero  = mul_prod == '0;
  assign mul_flags.neg   = mul_prod[WIDTH-1];
  assign mul_flags.carry = 1'b0;
  assign mul_flags.ovf   = mul_ovf;
  assign mul_flags.err   = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept && !is_mul) begin
      result_q <= alu_res;
      flags_q  <= alu_flags;
    end else if (state_q == MUL_RUN && mul_done) begin
      result_q <= mul_prod;
      flags_q  <= mul_flags;
    end
  end

  assign result = result_q;
  assign zero   = flags_q.zero;
  assign neg    = flags_q.neg;
  assign carry  = flags_q.carry;
  assign ovf    = flags_q.ovf;
  assign err    = flags_q.err;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed, table-driven bench for pipelined_alu
// at WIDTH=8 with handshake and reset sequences.
module tb_pipelined_alu;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             err;

  int checks;
  int errors;

  pipelined_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .data1     (data1),
    .data2     (data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags ordered {zero, neg, carry, ovf, err}
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [4:0] f;
  } vec_t;

  vec_t vecs[23];

  function automatic logic [4:0] flags();
    return {zero, neg, carry, ovf, err};
  endfunction

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  lat;
    int  exp_lat;
    bit  busy_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    exp_lat = (v.op == OP_MUL) ? WIDTH : 0;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    opcode   = v.op;
    data1    = v.a;
    data2    = v.b;
    @(negedge clk);
    lat     = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      in_valid = 1'($urandom);
      opcode   = 4'($urandom);
      data1    = 8'($urandom);
      data2    = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    in_valid = 1'b0;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_not_ready"}, busy_ok, 1);
    check({tag, "_result"}, result, v.r);
    check({tag, "_flags"}, flags(), v.f);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [7:0] hold_r;
    logic [4:0] hold_f;
    bit         seen;

    checks = 0;
    errors = 0;

    vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 5'b01010};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 5'b10100};
    vecs[2]  = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 5'b01000};
    vecs[3]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 5'b00110};
    vecs[4]  = '{OP_SUB, 8'h33, 8'h33, 8'h00, 5'b10100};
    vecs[5]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 5'b00000};
    vecs[6]  = '{OP_OR,  8'h0F, 8'h30, 8'h3F, 5'b00000};
    vecs[7]  = '{OP_XOR, 8'hFF, 8'hFF, 8'h00, 5'b10000};
    vecs[8]  = '{OP_FWD, 8'h12, 8'hA5, 8'hA5, 5'b01000};
    vecs[9]  = '{OP_MUL, 8'hFD, 8'h05, 8'hF1, 5'b01000};
    vecs[10] = '{OP_MUL, 8'h10, 8'h10, 8'h00, 5'b10010};
    vecs[11] = '{OP_MUL, 8'h80, 8'hFF, 8'h80, 5'b01010};
    vecs[12] = '{OP_MUL, 8'hF8, 8'hF8, 8'h40, 5'b00000};
    vecs[13] = '{OP_MUL, 8'h7F, 8'h7F, 8'h01, 5'b00010};
    vecs[14] = '{OP_SLL, 8'h81, 8'h09, 8'h02, 5'b00000};
    vecs[15] = '{OP_SRL, 8'h81, 8'h0C, 8'h08, 5'b00000};
    vecs[16] = '{OP_SRA, 8'h90, 8'h0B, 8'hF2, 5'b01000};
    vecs[17] = '{OP_ROR, 8'h81, 8'h01, 8'hC0, 5'b01000};
    vecs[18] = '{OP_ROL, 8'h81, 8'h01, 8'h03, 5'b00000};
    vecs[19] = '{OP_ROR, 8'h81, 8'h08, 8'h81, 5'b01000};
    vecs[20] = '{4'd13,  8'h55, 8'hAA, 8'h00, 5'b00001};
    vecs[21] = '{4'd15,  8'hFF, 8'h01, 8'h00, 5'b00001};
    vecs[22] = '{OP_MUL, 8'h03, 8'h00, 8'h00, 5'b10000};

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = '0;
    data1     = '0;
    data2     = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {out_valid, result, flags()}, '0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    for (int i = 0; i < 23; i++)
      run_vec(i, vecs[i]);

    // Backpressure: DONE must hold steady.
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = OP_ADD;
    data1    = 8'h7F;
    data2    = 8'h01;
    @(negedge clk);
    hold_r = result;
    hold_f = flags();
    check("bp_result", hold_r, 8'h80);
    check("bp_flags", hold_f, 5'b01010);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      opcode   = 4'(i);
      data1    = 8'($urandom);
      data2    = 8'($urandom);
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            {out_valid, in_ready, result, flags()},
            {2'b10, 8'h80, 5'b01010});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {out_valid, in_ready}, 2'b01);

    // Reset in MUL_RUN cycle 4 discards the product.
    in_valid = 1'b1;
    opcode   = OP_MUL;
    data1    = 8'h10;
    data2    = 8'h10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_mul_busy", in_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_now", {out_valid, result, flags()}, '0);
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_stale", seen, 0);
    check("rst_ready", in_ready, 1);
    check("rst_result", result, 8'h00);

    run_vec(100, vecs[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
